// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | audio_pkg : shared CIC/PCM constants and comb FSM state encoding    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package audio_pkg;

    localparam int CIC_ORDER = 4;
    localparam int CIC_DECIM = 64;
    localparam int CIC_W     = 29;
    localparam int PCM_W     = 16;
    localparam int PCM_MSB   = 28;

    // Full-scale CIC output magnitude is CIC_DECIM**CIC_ORDER = 2**CIC_GAIN_LOG2.
    localparam int CIC_GAIN_LOG2 = CIC_ORDER * $clog2(CIC_DECIM);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        C1   = 3'd2,
        C2   = 3'd3,
        C3   = 3'd4,
        C4   = 3'd5,
        OUT  = 3'd6
    } cic_state_t;

endpackage
`default_nettype wire

// File: rtl/ice40_pdm_decim_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ice40_pdm_decim_if : PCM sample stream towards the sample buffer    |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
interface ice40_pdm_decim_if;
    import audio_pkg::*;

    logic             smp_we;
    logic [PCM_W-1:0] smp_data;
    logic             sat;

    modport master (output smp_we, output smp_data, output sat);
    modport slave  (input  smp_we, input  smp_data, input  sat);

endinterface
`default_nettype wire

// File: rtl/ice40_pdm_clkgen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ice40_pdm_clkgen : PDM bit-clock divider, data synchroniser and     |
// |                    channel sampling strobe                          |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module ice40_pdm_clkgen #(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic lr_sel,
    input  logic pdm_data,
    output logic pdm_clk,
    output logic pstb,
    output logic pdm_bit
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_nxt;
    logic             run;
    logic             lr_lat;
    logic             sync1;
    logic             sync2;

    // The first enabled cycle holds the count at 0 so the PDM clock starts a full period.
    always_comb begin
        div_nxt = '0;
        if (en && run && (div_cnt != LAST_CNT)) begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            run     <= 1'b0;
            pdm_clk <= 1'b0;
            lr_lat  <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            run     <= en;
            pdm_clk <= en && (div_nxt < HALF_CNT);
            sync1   <= pdm_data;
            sync2   <= sync1;
            // Channel select is only allowed to change on a period boundary.
            if (!en || !run || (div_cnt == LAST_CNT)) begin
                lr_lat <= lr_sel;
            end
        end
    end

    assign pstb    = run && (div_cnt == (lr_lat ? LAST_CNT : HIGH_END));
    assign pdm_bit = sync2;

endmodule
`default_nettype wire

// File: rtl/ice40_pdm_decim.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ice40_pdm_decim : PDM microphone front end with 4th-order CIC       |
// |                   decimate-by-64 to signed 16-bit PCM               |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module ice40_pdm_decim
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 12,
    parameter int SETTLE  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_en,
    input  logic              i_lr_sel,
    input  logic              i_pdm_data,
    output logic              o_pdm_clk,
    ice40_pdm_decim_if.master smp
);

    localparam int PH_W     = $clog2(CIC_DECIM);
    localparam int SETTLE_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    // Align CIC full scale (2**CIC_GAIN_LOG2) with the PCM_MSB weight before slicing.
    localparam int OUT_MSB  = PCM_MSB - (PCM_MSB - CIC_GAIN_LOG2);
    localparam int OUT_LSB  = OUT_MSB - PCM_W + 1;

    localparam logic [PH_W-1:0]         PH_LAST   = PH_W'(CIC_DECIM - 1);
    localparam logic [SETTLE_W-1:0]     SETTLE_LD = SETTLE_W'(SETTLE);
    localparam logic signed [CIC_W-1:0] POS_FS    = CIC_W'(64'sd1 << CIC_GAIN_LOG2);

    logic                pstb;
    logic                pdm_bit;
    logic                dstb;
    logic [CIC_W-1:0]    x_in;
    logic [CIC_W-1:0]    integ [CIC_ORDER];
    logic [CIC_W-1:0]    dly   [CIC_ORDER];
    logic [CIC_W-1:0]    w;
    logic [CIC_W-1:0]    diff;
    logic [PH_W-1:0]     ph_cnt;
    logic [SETTLE_W-1:0] settle;
    logic [1:0]          stage_sel;
    logic                comb_active;
    logic                clip;
    logic [PCM_W-1:0]    pcm;
    logic                pcm_we;
    logic [PCM_W-1:0]    pcm_data;
    logic                pcm_sat;
    cic_state_t          state;
    cic_state_t          state_nxt;

    ice40_pdm_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .resetn   (resetn),
        .en       (i_en),
        .lr_sel   (i_lr_sel),
        .pdm_data (i_pdm_data),
        .pdm_clk  (o_pdm_clk),
        .pstb     (pstb),
        .pdm_bit  (pdm_bit)
    );

    assign x_in = pdm_bit ? CIC_W'(1) : {CIC_W{1'b1}};
    assign dstb = pstb && (ph_cnt == PH_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ph_cnt <= '0;
            for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
        end else if (!i_en) begin
            ph_cnt <= '0;
            for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
        end else if (pstb) begin
            ph_cnt   <= ph_cnt + 1'b1;
            integ[0] <= integ[0] + x_in;
            for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (!i_en) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stage_sel   = 2'd0;
        comb_active = 1'b0;
        case (state)
            IDLE:    if (dstb) state_nxt = SNAP;
            SNAP:    state_nxt = C1;
            C1:      begin state_nxt = C2;  comb_active = 1'b1; stage_sel = 2'd0; end
            C2:      begin state_nxt = C3;  comb_active = 1'b1; stage_sel = 2'd1; end
            C3:      begin state_nxt = C4;  comb_active = 1'b1; stage_sel = 2'd2; end
            C4:      begin state_nxt = OUT; comb_active = 1'b1; stage_sel = 2'd3; end
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign diff = w - dly[stage_sel];
    assign clip = ($signed(diff) >= POS_FS);
    assign pcm  = clip ? 16'h7FFF : diff[OUT_MSB:OUT_LSB];

    // The final comb result is registered on leaving C4 so data and strobe appear together in OUT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w        <= '0;
            for (int k = 0; k < CIC_ORDER; k++) dly[k] <= '0;
            settle   <= SETTLE_LD;
            pcm_we   <= 1'b0;
            pcm_sat  <= 1'b0;
            pcm_data <= '0;
        end else if (!i_en) begin
            w        <= '0;
            for (int k = 0; k < CIC_ORDER; k++) dly[k] <= '0;
            settle   <= SETTLE_LD;
            pcm_we   <= 1'b0;
            pcm_sat  <= 1'b0;
        end else begin
            pcm_we  <= 1'b0;
            pcm_sat <= 1'b0;
            if (state == SNAP) begin
                w <= integ[CIC_ORDER-1];
            end
            if (comb_active) begin
                w              <= diff;
                dly[stage_sel] <= w;
            end
            if ((state == C4) && (settle == '0)) begin
                pcm_data <= pcm;
                pcm_we   <= 1'b1;
                pcm_sat  <= clip;
            end
            if ((state == OUT) && (settle != '0)) begin
                settle <= settle - 1'b1;
            end
        end
    end

    assign smp.smp_we   = pcm_we;
    assign smp.smp_data = pcm_data;
    assign smp.sat      = pcm_sat;

endmodule
`default_nettype wire
